touch_i2c_target: RTL and testbench
===================================

TOUCH_I2C_TARGET -- requirements
Module: touch_i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h38, 7-bit I2C target address the block answers to.
REQ-002 Parameter THRESH_RST, default 8'd128, reset value of the threshold register.
REQ-003 Parameter FILT, default 3, number of consecutive equal samples required to accept an SCL/SDA level.
REQ-004 clk  input  1  system clock; one clock domain; all state on posedge clk.
REQ-005 arstn  input  1  reset; asynchronous assert, active-low.
REQ-006 touch  input  1  current touch present flag.
REQ-007 touchx  input  16  current X coordinate; bits [11:0] used.
REQ-008 touchy  input  16  current Y coordinate; bits [11:0] used.
REQ-009 thresh  output  8  threshold register contents.
REQ-010 busy  output  1  high from accepted address match to STOP or repeated START.
REQ-011 scl  inout  1  I2C clock; never driven, input only (no clock stretching).
REQ-012 sda  inout  1  I2C data; open-drain: driven 0 or released to z, never driven 1.

Function
REQ-013 SCL/SDA: 2-flop synchronizer, then FILT-sample glitch filter; all decoding uses filtered levels.
REQ-014 START = filtered SDA falls while SCL high; STOP = SDA rises while SCL high; START from any state -> ADDR, STOP from any state -> IDLE.
REQ-015 Bits sampled on filtered SCL rising edge, MSB first; SDA driven/released only in the clock after a filtered SCL falling edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 ADDR: after 8 bits, {ADDR,R/W} match -> ADDR_ACK (drive SDA 0 for the 9th bit); mismatch -> IDLE, SDA released.
REQ-018 After ADDR_ACK: W -> PTR; R -> RDATA.
REQ-019 PTR: 8 bits load register pointer, ACK, -> WDATA.
REQ-020 WDATA: 8 bits written to register[pointer], ACK always (read-only/unmapped writes discarded), pointer +1, -> WDATA.
REQ-021 RDATA: transmit register[pointer] MSB first; then RDATA_ACK samples controller bit: ACK(0) -> pointer +1, next byte; NACK(1) -> IDLE, SDA released until next START.
REQ-022 Pointer 8 bits, wraps 8'hFF -> 8'h00; pointer persists across transactions (write-pointer-then-repeated-START-read supported).
REQ-023 Register map: 0x02 = {7'b0, touch}; 0x03 = {touch ? 2'b10 : 2'b01, 2'b00, x[11:8]}; 0x04 = x[7:0]; 0x05 = {4'h0, y[11:8]}; 0x06 = y[7:0]; 0x80 = thresh (RW); all others read 8'h00.
REQ-024 touch/touchx/touchy snapshotted into shadow registers on every read-address ACK; all bytes of one read come from that snapshot.
REQ-025 Input change mid-read SHALL NOT alter bytes of the current transaction.
REQ-026 busy asserts in ADDR_ACK on match, deasserts on STOP, repeated START, or NACK in RDATA_ACK.

Reset
REQ-027 On arstn low: state IDLE, SDA released, pointer 8'h00, thresh = THRESH_RST, shadows 0, busy 0, filters/synchronizers to 1 (idle bus).
REQ-028 Reset mid-transaction releases SDA within the same cycle reset asserts (combinational from state), no spurious START/STOP on release.

Structure
REQ-029 Shared package: register address constants (NTOUCH 8'h02, T1_XHI..T1_YLO 8'h03..8'h06, THRESH 8'h80), state enum, default ADDR.
REQ-030 One sub-module: i2c_line_filter (synchronizer + FILT-sample filter + edge detect), instantiated twice (SCL, SDA).

Verification
REQ-031 Write {0x70},0x80,0x40,STOP -> three ACKs, thresh = 8'h40, busy low after STOP.
REQ-032 touch=1, x=0x123, y=0x0AB; write {0x70},0x02; rep-START {0x71}, read 5 bytes, NACK last -> 0x01,0x81,0x23,0x00,0xAB.
REQ-033 Address {0x72} -> no ACK (SDA high on 9th bit), state IDLE, busy stays 0.
REQ-034 Set pointer 0xFF, read 2 bytes -> 0x00 then 0x00 (wrap to reg 0x00), pointer = 0x01 after.
REQ-035 Change x from 0x123 to 0x456 between bytes 2 and 3 of a read -> bytes still 0x81,0x23; next transaction returns 0x84,0x56.
REQ-036 Assert arstn low mid-RDATA with SDA driven low -> SDA z immediately, thresh = 8'd128, next valid transaction ACKed.

Source files
------------

// File: rtl/touch_i2c_target_pkg.sv
// Shared constants for the touch controller I2C target: register map, FSM encodings, default address.
// Also holds the register read mux so every user decodes the map identically.
package touch_i2c_target_pkg;

  localparam logic [6:0] ADDR_DEFAULT = 7'h38;

  localparam logic [7:0] REG_NTOUCH = 8'h02;
  localparam logic [7:0] REG_T1_XHI = 8'h03;
  localparam logic [7:0] REG_T1_XLO = 8'h04;
  localparam logic [7:0] REG_T1_YHI = 8'h05;
  localparam logic [7:0] REG_T1_YLO = 8'h06;
  localparam logic [7:0] REG_THRESH = 8'h80;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_ADDR      = 4'd1;
  localparam state_t S_ADDR_ACK  = 4'd2;
  localparam state_t S_PTR       = 4'd3;
  localparam state_t S_PTR_ACK   = 4'd4;
  localparam state_t S_WDATA     = 4'd5;
  localparam state_t S_WDATA_ACK = 4'd6;
  localparam state_t S_RDATA     = 4'd7;
  localparam state_t S_RDATA_ACK = 4'd8;

  function automatic logic [7:0] reg_read(
    input logic [7:0]  addr,
    input logic        t,
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [7:0]  th
  );
    logic [7:0] val;
    val = 8'h00;
    case (addr)
      REG_NTOUCH: val = {7'b0, t};
      REG_T1_XHI: val = {(t ? 2'b10 : 2'b01), 2'b00, x[11:8]};
      REG_T1_XLO: val = x[7:0];
      REG_T1_YHI: val = {4'h0, y[11:8]};
      REG_T1_YLO: val = y[7:0];
      REG_THRESH: val = th;
      default:    val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/touch_i2c_target_line_filter.sv
// Bus line conditioner: 2-flop sync, FILT-sample agreement filter, one-cycle rise/fall pulses.
// Latency 2 + FILT + 1 clocks; no backpressure. Resets to the idle (high) level.
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic arstn,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic            sync1;
  logic            sync2;
  logic [FILT-1:0] hist;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= '1;
      lvl   <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      hist[0] <= sync2;
      for (int i = 1; i < FILT; i++) hist[i] <= hist[i-1];
      rise <= 1'b0;
      fall <= 1'b0;
      // level only moves once FILT consecutive samples agree on the new value
      if ((&hist) && !lvl) begin
        lvl  <= 1'b1;
        rise <= 1'b1;
      end else if (!(|hist) && lvl) begin
        lvl  <= 1'b0;
        fall <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/touch_i2c_target.sv
// I2C target exposing touch status/coordinates and a RW threshold register; pointer auto-increments.
// SDA changes one clock after a filtered SCL fall; no clock stretching, the controller paces everything.
module touch_i2c_target
  import touch_i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR       = ADDR_DEFAULT,
  parameter logic [7:0] THRESH_RST = 8'd128,
  parameter int         FILT       = 3
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        touch,
  input  logic [15:0] touchx,
  input  logic [15:0] touchy,
  output logic [7:0]  thresh,
  output logic        busy,
  inout  wire         scl,
  inout  wire         sda
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk   (clk),
    .arstn (arstn),
    .din   (scl),
    .lvl   (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk   (clk),
    .arstn (arstn),
    .din   (sda),
    .lvl   (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  sh;
  logic [7:0]  tx;
  logic [7:0]  ptr;
  logic        rw;
  logic        ack_bit;
  logic        sda_oe;
  logic        sh_touch;
  logic [11:0] sh_x;
  logic [11:0] sh_y;
  logic [7:0]  rd_val;
  logic        start_det;
  logic        stop_det;
  logic        unused_hi;

  assign unused_hi = ^{touchx[15:12], touchy[15:12]};

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // reads always come from the snapshot taken at the read-address ACK
  assign rd_val = reg_read(ptr, sh_touch, sh_x, sh_y, thresh);

  // open drain: only ever pull low; oe is async-reset so SDA frees the instant arstn drops
  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      sh       <= 8'h00;
      tx       <= 8'h00;
      ptr      <= 8'h00;
      rw       <= 1'b0;
      ack_bit  <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      thresh   <= THRESH_RST;
      sh_touch <= 1'b0;
      sh_x     <= 12'h000;
      sh_y     <= 12'h000;
    end else if (start_det) begin
      state  <= S_ADDR;
      cnt    <= 4'd0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else if (stop_det) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            sh  <= {sh[6:0], sda_lvl};
            cnt <= cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt <= 4'd0;
            if (sh[7:1] == ADDR) begin
              state  <= S_ADDR_ACK;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= sh[0];
              if (sh[0]) begin
                sh_touch <= touch;
                sh_x     <= touchx[11:0];
                sh_y     <= touchy[11:0];
              end
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt <= 4'd0;
            if (rw) begin
              state  <= S_RDATA;
              tx     <= rd_val;
              sda_oe <= ~rd_val[7];
            end else begin
              state  <= S_PTR;
              sda_oe <= 1'b0;
            end
          end
        end
        S_PTR: begin
          if (scl_rise) begin
            sh  <= {sh[6:0], sda_lvl};
            cnt <= cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt    <= 4'd0;
            ptr    <= sh;
            state  <= S_PTR_ACK;
            sda_oe <= 1'b1;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state  <= S_WDATA;
            sda_oe <= 1'b0;
            cnt    <= 4'd0;
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            sh  <= {sh[6:0], sda_lvl};
            cnt <= cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (ptr == REG_THRESH) thresh <= sh;
            ptr    <= ptr + 8'd1;
            cnt    <= 4'd0;
            state  <= S_WDATA_ACK;
            sda_oe <= 1'b1;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt <= cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              // pointer advances per byte sent, whether or not the controller ACKs it
              state  <= S_RDATA_ACK;
              sda_oe <= 1'b0;
              ptr    <= ptr + 8'd1;
              cnt    <= 4'd0;
            end else if (cnt != 4'd0) begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            ack_bit <= sda_lvl;
          end else if (scl_fall) begin
            if (!ack_bit) begin
              state  <= S_RDATA;
              tx     <= rd_val;
              sda_oe <= ~rd_val[7];
              cnt    <= 4'd0;
            end else begin
              state  <= S_IDLE;
              sda_oe <= 1'b0;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_i2c_target.sv
// Bench for touch_i2c_target: bit-banged I2C controller with a queue of expected ACKs and read bytes.
module tb_touch_i2c_target;
  import touch_i2c_target_pkg::*;

  localparam int Q = 12;

  logic        clk = 1'b0;
  logic        arstn;
  logic        touch;
  logic [15:0] touchx;
  logic [15:0] touchy;
  logic [7:0]  thresh;
  logic        busy;
  logic        scl_low;
  logic        sda_low;
  wire         scl;
  wire         sda;

  pullup pu_scl (scl);
  pullup pu_sda (sda);
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  touch_i2c_target dut (
    .clk    (clk),
    .arstn  (arstn),
    .touch  (touch),
    .touchx (touchx),
    .touchy (touchy),
    .thresh (thresh),
    .busy   (busy),
    .scl    (scl),
    .sda    (sda)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) chk({tag, " (no expectation queued)"}, {24'h0, got}, 32'hFFFF_FFFF);
    else chk(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; quarter();
    scl_low = 1'b0; quarter();
    sda_low = 1'b1; quarter();
    scl_low = 1'b1; quarter();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; quarter();
    scl_low = 1'b0; quarter();
    sda_low = 1'b0; quarter();
    quarter();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~b[i]; quarter();
      scl_low = 1'b0;  quarter();
      quarter();
      scl_low = 1'b1;  quarter();
    end
    sda_low = 1'b0; quarter();
    scl_low = 1'b0; quarter();
    ack = sda;      quarter();
    scl_low = 1'b1; quarter();
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_low = 1'b0; quarter();
      scl_low = 1'b0; quarter();
      b[i] = sda;     quarter();
      scl_low = 1'b1; quarter();
    end
    sda_low = ~nack; quarter();
    scl_low = 1'b0;  quarter();
    quarter();
    scl_low = 1'b1;  quarter();
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    exp_q.push_back({7'b0, exp_ack});
    wr_byte(b, a);
    sb_chk(tag, {7'b0, a});
  endtask

  task automatic recv(input string tag, input logic nack, input logic [7:0] exp);
    logic [7:0] b;
    exp_q.push_back(exp);
    rd_byte(nack, b);
    sb_chk(tag, b);
  endtask

  initial begin
    arstn   = 1'b0;
    scl_low = 1'b0;
    sda_low = 1'b0;
    touch   = 1'b1;
    touchx  = 16'h0123;
    touchy  = 16'h00AB;
    repeat (5) @(negedge clk);
    arstn = 1'b1;
    quarter();
    chk("rst_thresh", 32'(thresh), 32'd128);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));

    // threshold write
    i2c_start();
    send("w1_addr_ack", 8'h70, 1'b0);
    send("w1_ptr_ack", 8'h80, 1'b0);
    chk("w1_busy", 32'(busy), 32'd1);
    send("w1_data_ack", 8'h40, 1'b0);
    i2c_stop();
    chk("w1_thresh", 32'(thresh), 32'h40);
    chk("w1_busy_stop", 32'(busy), 32'd0);

    // pointer write, repeated start, 5-byte read
    i2c_start();
    send("r1_waddr_ack", 8'h70, 1'b0);
    send("r1_ptr_ack", 8'h02, 1'b0);
    i2c_start();
    send("r1_raddr_ack", 8'h71, 1'b0);
    recv("r1_ntouch", 1'b0, 8'h01);
    recv("r1_xhi", 1'b0, 8'h81);
    recv("r1_xlo", 1'b0, 8'h23);
    recv("r1_yhi", 1'b0, 8'h00);
    recv("r1_ylo", 1'b1, 8'hAB);
    chk("r1_busy_nack", 32'(busy), 32'd0);
    i2c_stop();

    // foreign address
    i2c_start();
    send("bad_addr_nack", 8'h72, 1'b1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_state", 32'(dut.state), 32'(S_IDLE));
    i2c_stop();

    // pointer wrap 0xFF -> 0x00, then continue from 0x01
    i2c_start();
    send("wrap_waddr_ack", 8'h70, 1'b0);
    send("wrap_ptr_ack", 8'hFF, 1'b0);
    i2c_start();
    send("wrap_raddr_ack", 8'h71, 1'b0);
    recv("wrap_ff", 1'b0, 8'h00);
    recv("wrap_00", 1'b1, 8'h00);
    i2c_stop();
    i2c_start();
    send("cont_raddr_ack", 8'h71, 1'b0);
    recv("cont_01", 1'b0, 8'h00);
    recv("cont_02", 1'b1, 8'h01);
    i2c_stop();

    // coordinate change mid-read must not leak into the current transaction
    i2c_start();
    send("snap_waddr_ack", 8'h70, 1'b0);
    send("snap_ptr_ack", 8'h02, 1'b0);
    i2c_start();
    send("snap_raddr_ack", 8'h71, 1'b0);
    recv("snap_ntouch", 1'b0, 8'h01);
    recv("snap_xhi", 1'b0, 8'h81);
    touchx = 16'h0456;
    recv("snap_xlo", 1'b1, 8'h23);
    i2c_stop();
    i2c_start();
    send("snap2_waddr_ack", 8'h70, 1'b0);
    send("snap2_ptr_ack", 8'h03, 1'b0);
    i2c_start();
    send("snap2_raddr_ack", 8'h71, 1'b0);
    recv("snap2_xhi", 1'b0, 8'h84);
    recv("snap2_xlo", 1'b1, 8'h56);
    i2c_stop();

    // reset while the target is pulling SDA low (thresh 0x40 has MSB 0)
    i2c_start();
    send("rst_waddr_ack", 8'h70, 1'b0);
    send("rst_ptr_ack", 8'h80, 1'b0);
    i2c_start();
    send("rst_raddr_ack", 8'h71, 1'b0);
    chk("rst_sda_driven", 32'(sda), 32'd0);
    arstn = 1'b0;
    #1;
    chk("rst_sda_released", 32'(sda), 32'd1);
    chk("rst_thresh_mid", 32'(thresh), 32'd128);
    chk("rst_busy_mid", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    quarter();
    i2c_start();
    send("post_waddr_ack", 8'h70, 1'b0);
    send("post_ptr_ack", 8'h80, 1'b0);
    send("post_data_ack", 8'h55, 1'b0);
    i2c_stop();
    chk("post_thresh", 32'(thresh), 32'h55);
    i2c_start();
    send("post_w2_ack", 8'h70, 1'b0);
    send("post_p2_ack", 8'h80, 1'b0);
    i2c_start();
    send("post_raddr_ack", 8'h71, 1'b0);
    recv("post_thresh_rd", 1'b1, 8'h55);
    i2c_stop();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
